// File: rtl/counter_sched.sv
// counter_sched
// Round-robin command scheduler that shares one loadable up-counter among
// NREQ requesters. Each command carries an optional load value and a run
// length. The block arbitrates, sequences the counter's load/enable
// controls and reports the resulting count with a one-cycle done pulse.
//
// Ports
//   clk, rst_   : clock, asynchronous active-low reset
//   req         : per-requester command request
//   cmd_load    : per-requester, 1 = load cmd_data before the run
//   cmd_data    : per-requester load value, slice i = [i*W +: W]
//   cmd_len     : per-requester increment count, slice i = [i*LW +: LW]
//   gnt         : one-hot pulse, command of requester i accepted
//   done        : one-cycle pulse, command complete
//   done_id     : requester index of the completed command
//   done_count  : counter value during done, 0 otherwise
//   busy        : high whenever the scheduler is not idle
//   ctr_load    : counter load strobe
//   ctr_data    : counter load data (holds the last latched value)
//   ctr_enable  : counter increment enable
//   ctr_count   : counter output
module counter_sched #(
  parameter int NREQ = 4,
  parameter int W    = 5,
  parameter int LW   = 4
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           cmd_load,
  input  logic [NREQ*W-1:0]         cmd_data,
  input  logic [NREQ*LW-1:0]        cmd_len,
  output logic [NREQ-1:0]           gnt,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [W-1:0]              done_count,
  output logic                      busy,
  output logic                      ctr_load,
  output logic [W-1:0]              ctr_data,
  output logic                      ctr_enable,
  input  logic [W-1:0]              ctr_count
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // State and latched command
  state_t           state_r;
  state_t           state_s;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   ptr_s;
  logic [IDW-1:0]   id_r;
  logic [IDW-1:0]   id_s;
  logic [LW-1:0]    len_r;
  logic [LW-1:0]    len_s;
  logic [LW-1:0]    rem_r;
  logic [LW-1:0]    rem_s;
  logic [W-1:0]     data_s;

  // Registered outputs
  logic [NREQ-1:0]  gnt_r;
  logic [NREQ-1:0]  gnt_s;
  logic             done_r;
  logic             done_s;
  logic [IDW-1:0]   done_id_r;
  logic [IDW-1:0]   done_id_s;
  logic             busy_r;
  logic             busy_s;
  logic             ctr_load_r;
  logic             ctr_load_s;
  logic             ctr_enable_r;
  logic             ctr_enable_s;
  logic [W-1:0]     ctr_data_r;

  // Arbitration result
  logic             win_found_s;
  logic [IDW-1:0]   win_id_s;
  int               scan_idx_s;
  logic             win_load_s;
  logic [W-1:0]     win_data_s;
  logic [LW-1:0]    win_len_s;

  // Round-robin search: first requester strictly after ptr, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = {IDW{1'b0}};
    scan_idx_s  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx_s = (int'(ptr_r) + k) % NREQ;
      if (!win_found_s && req[scan_idx_s]) begin
        win_found_s = 1'b1;
        win_id_s    = scan_idx_s[IDW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Extract the winner's command fields from the flat buses.
  always_comb begin
    win_load_s = cmd_load[win_id_s];
    win_data_s = cmd_data[int'(win_id_s)*W +: W];
    win_len_s  = cmd_len[int'(win_id_s)*LW +: LW];
  end

  // Next-state logic and next values for the latched command fields.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    id_s    = id_r;
    len_s   = len_r;
    rem_s   = rem_r;
    data_s  = ctr_data_r;
    gnt_s   = {NREQ{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          ptr_s  = win_id_s;
          id_s   = win_id_s;
          len_s  = win_len_s;
          rem_s  = win_len_s;
          data_s = win_data_s;
          gnt_s  = NREQ'(1) << win_id_s;
          if (win_load_s) begin
            state_s = ST_LOAD;
          end else if (win_len_s != {LW{1'b0}}) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // The run down-counter is reloaded here so RUN always starts at len.
        rem_s = len_r;
        if (len_r != {LW{1'b0}}) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_RUN: begin
        rem_s = rem_r - LW'(1);
        if (rem_r <= LW'(1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output values are decoded from the next state so that the registered
  // outputs line up with the state they describe.
  always_comb begin
    ctr_load_s   = (state_s == ST_LOAD);
    ctr_enable_s = (state_s == ST_RUN);
    done_s       = (state_s == ST_DONE);
    busy_s       = (state_s != ST_IDLE);
    if (state_s == ST_DONE) begin
      done_id_s = id_s;
    end else begin
      done_id_s = {IDW{1'b0}};
    end
  end

  // State, latched command and registered outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_r      <= ST_IDLE;
      ptr_r        <= IDW'(NREQ - 1);
      id_r         <= {IDW{1'b0}};
      len_r        <= {LW{1'b0}};
      rem_r        <= {LW{1'b0}};
      ctr_data_r   <= {W{1'b0}};
      gnt_r        <= {NREQ{1'b0}};
      done_r       <= 1'b0;
      done_id_r    <= {IDW{1'b0}};
      busy_r       <= 1'b0;
      ctr_load_r   <= 1'b0;
      ctr_enable_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      id_r         <= id_s;
      len_r        <= len_s;
      rem_r        <= rem_s;
      ctr_data_r   <= data_s;
      gnt_r        <= gnt_s;
      done_r       <= done_s;
      done_id_r    <= done_id_s;
      busy_r       <= busy_s;
      ctr_load_r   <= ctr_load_s;
      ctr_enable_r <= ctr_enable_s;
    end
  end

  assign gnt        = gnt_r;
  assign done       = done_r;
  assign done_id    = done_id_r;
  assign busy       = busy_r;
  assign ctr_load   = ctr_load_r;
  assign ctr_data   = ctr_data_r;
  assign ctr_enable = ctr_enable_r;

  // The counter is itself registered, so during the done cycle its output
  // already reflects the final enable; passing it through gated by done
  // avoids predicting the counter's next value here.
  assign done_count = done_r ? ctr_count : {W{1'b0}};

endmodule

// File: tb/tb_counter_sched.sv
// Testbench for counter_sched: behavioural counter, scoreboard queues filled
// by the stimulus side from a count/round-robin model, monitor compares.
module tb_counter_sched;

  localparam int NREQ = 4;
  localparam int W    = 5;
  localparam int LW   = 4;
  localparam int IDW  = 2;

  logic                  clk = 1'b0;
  logic                  rst_ = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ-1:0]       cmd_load = '0;
  logic [NREQ*W-1:0]     cmd_data = '0;
  logic [NREQ*LW-1:0]    cmd_len = '0;
  logic [NREQ-1:0]       gnt;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [W-1:0]          done_count;
  logic                  busy;
  logic                  ctr_load;
  logic [W-1:0]          ctr_data;
  logic                  ctr_enable;
  logic [W-1:0]          ctr_count;

  counter_sched #(.NREQ(NREQ), .W(W), .LW(LW)) dut (
    .clk(clk), .rst_(rst_), .req(req), .cmd_load(cmd_load),
    .cmd_data(cmd_data), .cmd_len(cmd_len), .gnt(gnt), .done(done),
    .done_id(done_id), .done_count(done_count), .busy(busy),
    .ctr_load(ctr_load), .ctr_data(ctr_data), .ctr_enable(ctr_enable),
    .ctr_count(ctr_count)
  );

  always #5 clk = ~clk;

  // Shared counter instance: registered, load has priority, shares rst_.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) ctr_count <= '0;
    else if (ctr_load) ctr_count <= ctr_data;
    else if (ctr_enable) ctr_count <= ctr_count + 5'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int id; int gap; } gexp_t;
  typedef struct { int id; int count; int lat; int nload; int nen; int data; } dexp_t;
  gexp_t gq[$];
  dexp_t dq[$];

  // Reference model state
  int ref_count = 0;
  int ref_ptr   = NREQ - 1;

  logic           b_load [NREQ];
  logic [W-1:0]   b_data [NREQ];
  logic [LW-1:0]  b_len  [NREQ];

  function automatic int pick(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (ref_ptr + k) % NREQ;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive_fields();
    for (int i = 0; i < NREQ; i++) begin
      cmd_load[i]           = b_load[i];
      cmd_data[i*W +: W]    = b_data[i];
      cmd_len[i*LW +: LW]   = b_len[i];
    end
  endtask

  // Push the predicted outcome of a batch, then drive it. rr_grants=0 means
  // each requester in mask is served once and drops req in its gnt cycle;
  // otherwise req stays high for rr_grants grants.
  task automatic issue(input logic [NREQ-1:0] mask, input int rr_grants);
    logic [NREQ-1:0] pend;
    int n, prev_d, d, w, seen, t;
    pend   = mask;
    prev_d = -1;
    n      = (rr_grants > 0) ? rr_grants : $countones(mask);
    for (int g = 0; g < n; g++) begin
      w = pick(pend);
      gq.push_back('{id: w, gap: (prev_d < 0) ? -1 : prev_d + 2});
      d = (b_load[w] ? 1 : 0) + int'(b_len[w]);
      if (b_load[w]) ref_count = int'(b_data[w]);
      ref_count = (ref_count + int'(b_len[w])) % (1 << W);
      dq.push_back('{id: w, count: ref_count, lat: d, nload: b_load[w] ? 1 : 0,
                     nen: int'(b_len[w]), data: int'(b_data[w])});
      ref_ptr = w;
      prev_d  = d;
      if (rr_grants == 0) pend[w] = 1'b0;
    end
    drive_fields();
    req  = mask;
    seen = 0;
    t    = 0;
    while (seen < n && t < 400) begin
      @(negedge clk);
      t++;
      if (|gnt) begin
        seen++;
        if (rr_grants == 0) req = req & ~gnt;
        else if (seen == n) req = '0;
      end
    end
    check("grant_count", seen, n);
    req = '0;
    t = 0;
    while (dq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("done_drain", dq.size(), 0);
    gq.delete();
    dq.delete();
    @(negedge clk);
  endtask

  // Monitor: per-cycle invariants plus scoreboard pops on gnt and done.
  initial begin
    int last_gnt, n_load, n_en, gid;
    gexp_t ge;
    dexp_t de;
    last_gnt = 0; n_load = 0; n_en = 0;
    forever begin
      @(negedge clk);
      if (!rst_) begin
        n_load = 0;
        n_en   = 0;
      end else begin
        check("gnt_onehot0", $onehot0(gnt), 1);
        check("load_enable_exclusive", ctr_load & ctr_enable, 0);
        if (!done) check("done_count_zero_idle", done_count, 0);
        if (|gnt) begin
          gid = -1;
          for (int i = 0; i < NREQ; i++) if (gnt[i]) gid = i;
          check("gnt_expected", gq.size() != 0, 1);
          if (gq.size() != 0) begin
            ge = gq.pop_front();
            check("gnt_id", gid, ge.id);
            if (ge.gap >= 0) check("gnt_spacing", cyc - last_gnt, ge.gap);
          end
          last_gnt = cyc;
          n_load   = 0;
          n_en     = 0;
        end
        if (ctr_load) begin
          n_load++;
          if (dq.size() != 0) check("ctr_data_on_load", ctr_data, dq[0].data);
        end
        if (ctr_enable) n_en++;
        if (done) begin
          check("done_expected", dq.size() != 0, 1);
          if (dq.size() != 0) begin
            de = dq.pop_front();
            check("done_id", done_id, de.id);
            check("done_count", done_count, de.count);
            check("done_latency", cyc - last_gnt, de.lat);
            check("load_cycles", n_load, de.nload);
            check("enable_cycles", n_en, de.nen);
            check("ctr_data_hold", ctr_data, de.data);
            check("busy_in_done", busy, 1);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    check(name, {gnt, done, done_id, done_count, busy, ctr_load, ctr_data, ctr_enable}, 0);
    check({name, "_count"}, ctr_count, 0);
  endtask

  task automatic set_cmd(input int i, input logic l, input int dat, input int len);
    b_load[i] = l;
    b_data[i] = W'(dat);
    b_len[i]  = LW'(len);
  endtask

  initial begin
    int t, en;
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_ = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Read after reset, load-and-run, read no-op, wrap-around
    issue(4'b0001, 0);
    set_cmd(0, 1'b1, 10, 3);
    issue(4'b0001, 0);
    set_cmd(2, 1'b0, 0, 0);
    issue(4'b0100, 0);
    set_cmd(1, 1'b1, 30, 4);
    issue(4'b0010, 0);

    // Reset in the third RUN cycle of a load command
    set_cmd(3, 1'b1, 5, 8);
    gq.push_back('{id: 3, gap: -1});
    dq.push_back('{id: 3, count: 13, lat: 9, nload: 1, nen: 8, data: 5});
    drive_fields();
    req = 4'b1000;
    t = 0; en = 0;
    while (en < 3 && t < 50) begin
      @(negedge clk);
      t++;
      if (|gnt) req = '0;
      if (ctr_enable) en++;
    end
    check("run_cycles_before_reset", en, 3);
    rst_ = 1'b0;
    #1;
    check_all_zero("midrun_reset_outputs");
    req = '0;
    gq.delete();
    dq.delete();
    ref_count = 0;
    ref_ptr   = NREQ - 1;
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    repeat (4) @(negedge clk);
    check("no_done_after_reset", {done, busy}, 0);

    // Requester 0 and 3 together after reset: 0 first
    set_cmd(0, 1'b1, 7, 2);
    set_cmd(3, 1'b0, 0, 5);
    issue(4'b1001, 0);

    // Round-robin among 0,1,3 with reads held high
    set_cmd(0, 1'b0, 0, 0);
    set_cmd(1, 1'b0, 0, 0);
    set_cmd(3, 1'b0, 0, 0);
    issue(4'b1011, 6);

    // Randomized batches
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++)
        set_cmd(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 15)));
      issue(4'($urandom_range(1, 15)), 0);
    end

    check("leftover_gnt_expect", gq.size(), 0);
    check("leftover_done_expect", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin command scheduler that shares one 5-bit loadable up-counter among NREQ requesters. Each requester posts a command: an optional load value plus an increment run length. The block arbitrates between requesters, sequences the counter's load/enable controls, and returns the resulting count with a completion pulse. It sits between the requester agents and the counter instance, and is the only driver of the counter's load, data and enable inputs.

## Interface
- NREQ, 4: number of requesters (2..8)
- W, 5: counter/data width; matches the counter instance
- LW, 4: run-length width; a run is 0..2^LW-1 increments
- clk  in  1  clock
- rst_  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester command request
- cmd_load  in  NREQ  per-requester: 1 = load cmd_data before the run
- cmd_data  in  NREQ*W  per-requester load value; slice i = [i*W +: W]
- cmd_len  in  NREQ*LW  per-requester increment count; slice i = [i*LW +: LW]
- gnt  out  NREQ  one-hot, one-cycle pulse: command of requester i accepted
- done  out  1  one-cycle pulse: command complete
- done_id  out  $clog2(NREQ)  requester index of the completed command
- done_count  out  W  counter value at completion; 0 when done=0
- busy  out  1  high in every state except IDLE
- ctr_load  out  1  to counter load
- ctr_data  out  W  to counter data
- ctr_enable  out  1  to counter enable
- ctr_count  in  W  from counter count

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset state is IDLE.
- IDLE:
  - If any req bit is set, pick the winner round-robin: search from ptr+1 upward, wrapping.
  - Latch the winner's id, cmd_load, cmd_data and cmd_len. Set ptr = winner.
  - Next state: LOAD if cmd_load=1; else RUN if cmd_len≠0; else DONE.
- LOAD: ctr_load=1, ctr_data=latched data. Next state: RUN if len≠0, else DONE.
- RUN:
  - ctr_enable=1 for exactly len consecutive cycles; an internal down-counter is loaded with len.
  - After the last enable cycle, go to DONE.
- DONE: done=1, done_id=latched id, done_count=ctr_count. Next state: IDLE.
- A command with load=0 and len=0 is a read: it produces no counter activity and returns the current count.
- gnt[id] is registered. It is high only in the first cycle after leaving IDLE, whichever of LOAD, RUN or DONE that is.
- A requester must hold req and its command fields stable until it sees gnt. It may drop or change them in the gnt cycle. No other requester is affected.
- Requests are never sampled outside IDLE. Pending requests wait for the next IDLE.
- Arithmetic is modulo 2^W: the counter wraps 31→0. The scheduler neither detects nor flags the wrap.
- ctr_load and ctr_enable are never high in the same cycle.
- ctr_data holds the latched value whenever ctr_load=0, and is 0 out of reset.
- Reset value of ptr is NREQ-1, so requester 0 has first priority after reset.
- Reset mid-operation:
  - All state is cleared asynchronously and the command in flight is dropped, with no done.
  - All outputs go to 0 immediately: gnt, done, done_id, done_count, busy, ctr_load, ctr_data, ctr_enable.
  - The counter shares rst_ and clears to 0 in the same way.

## Timing
- A request is sampled in IDLE cycle T.
- Load command with len=L≥1:
  - gnt and ctr_load in T+1.
  - ctr_enable in T+2..T+1+L.
  - done in T+2+L.
  - Back in IDLE at T+3+L.
- No-load command with L≥1: gnt and first enable in T+1, done in T+1+L.
- Read command: gnt and done both in T+1; IDLE at T+2.
- Minimum spacing between grants is 2 cycles.
- done_count is valid during the done cycle only. The counter is registered, so its output already includes the final enable.

## Test plan
- Reset: hold rst_ low, then release.
  - Required: all outputs 0 and busy=0.
  - Required: a read from req[0] returns done_count=0 with done_id=0.
- Load and run: req[0] with load=1, data=10, len=3 in cycle T.
  - Required: gnt[0] and ctr_load (ctr_data=10) in T+1.
  - Required: ctr_enable in T+2..T+4.
  - Required: done in T+5 with done_id=0, done_count=13.
- Wrap-around: req[1] with load=1, data=30, len=4.
  - Required: 4 enable cycles, then done_count=2 with done_id=1.
- Round-robin: req[0], req[1] and req[3] held high continuously with read commands.
  - Required: grant order 0,1,3,0,1,3, one grant every 2 cycles.
  - Required: req[2] is never granted and gnt is never multi-hot.
- Read with no-op: after the load-and-run scenario, req[2] issues a read (load=0, len=0).
  - Required: done in T+1 with done_count=13.
  - Required: ctr_load and ctr_enable stay 0 throughout.
- Reset mid-RUN: req[3] with load=1, data=5, len=8; pull rst_ low in the third RUN cycle.
  - Required: all outputs 0 immediately, and no done for that command.
  - After release, with req[0] and req[3] both set, required: gnt[0] first.
